// File: rtl/ram_scan_disp.sv
// Read-side scanner for the 32x8 dual-port RAM demo: steps through RAM addresses on a
// prescaled tick or a step pulse and presents {address, data} as four hex digits.
module ram_scan_disp #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int TICK_DIV = 50000000,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [3:0]        dig3,
    output logic [3:0]        dig2,
    output logic [3:0]        dig1,
    output logic [3:0]        dig0,
    output logic              disp_valid,
    output logic              busy
);

    localparam int             CNT_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [2:0]     WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_READ = 3'd2,
        S_WAIT = 3'd3,
        S_CAP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  presc_q, presc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic [2:0]        wait_q, wait_d;
    logic [3:0]        dig3_q, dig3_d;
    logic [3:0]        dig2_q, dig2_d;
    logic [3:0]        dig1_q, dig1_d;
    logic [3:0]        dig0_q, dig0_d;
    logic              valid_q, valid_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;
    logic              tick_s;
    logic              req_s;
    logic [7:0]        addr_pad_s;

    assign tick_s     = run && (presc_q == CNT_MAX);
    assign req_s      = tick_s || step;
    assign addr_pad_s = 8'(addr_q);

    // Next-state logic for prescaler, scan FSM, pending flag and display digits.
    always_comb begin
        presc_d = presc_q;
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        wait_d  = wait_q;
        dig3_d  = dig3_q;
        dig2_d  = dig2_q;
        dig1_d  = dig1_q;
        dig0_d  = dig0_q;
        valid_d = valid_q;

        if (!run) begin
            presc_d = '0;
        end else if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        // IDLE is the only state that consumes a request; elsewhere it is remembered once.
        if (state_q == S_IDLE) begin
            pend_d = 1'b0;
        end else if (req_s) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        case (state_q)
            S_INIT: begin
                state_d = S_READ;
            end
            S_IDLE: begin
                if (req_s || pend_q) begin
                    state_d = S_READ;
                    addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (RD_LAT > 1) begin
                    state_d = S_WAIT;
                    wait_d  = WAIT_INIT;
                end else begin
                    state_d = S_CAP;
                end
            end
            S_WAIT: begin
                if (wait_q == 3'd0) begin
                    state_d = S_CAP;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            S_CAP: begin
                dig3_d  = addr_pad_s[7:4];
                dig2_d  = addr_pad_s[3:0];
                dig1_d  = rd_data[7:4];
                dig0_d  = rd_data[3:0];
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        rd_en_d = (state_d == S_READ);
        busy_d  = (state_d != S_IDLE);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            presc_q <= '0;
            addr_q  <= '0;
            pend_q  <= 1'b0;
            wait_q  <= 3'd0;
            dig3_q  <= 4'd0;
            dig2_q  <= 4'd0;
            dig1_q  <= 4'd0;
            dig0_q  <= 4'd0;
            valid_q <= 1'b0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            wait_q  <= wait_d;
            dig3_q  <= dig3_d;
            dig2_q  <= dig2_d;
            dig1_q  <= dig1_d;
            dig0_q  <= dig0_d;
            valid_q <= valid_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
        end
    end

    assign rd_addr    = addr_q;
    assign rd_en      = rd_en_q;
    assign dig3       = dig3_q;
    assign dig2       = dig2_q;
    assign dig1       = dig1_q;
    assign dig0       = dig0_q;
    assign disp_valid = valid_q;
    assign busy       = busy_q;

    ram_scan_disp_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en_q),
        .busy       (busy_q),
        .disp_valid (valid_q)
    );

endmodule

// Protocol checks on the scanner outputs.
module ram_scan_disp_chk (
    input logic clk,
    input logic rst,
    input logic rd_en,
    input logic busy,
    input logic disp_valid
);

    a_rd_en_single: assert property (@(posedge clk) rd_en |=> !rd_en);
    a_rd_en_busy:   assert property (@(posedge clk) rd_en |-> busy);
    a_valid_sticky: assert property (@(posedge clk) (!rst && disp_valid) |=> disp_valid);

endmodule
